andla_csr_exram_bank: RTL and testbench
=======================================

# andla_csr_exram_bank

Parametrised CSR bank for the external-RAM base-address channels, plus a saturating credit counter and a snapshot-read cycle counter. It generalises the fixed eight-channel `rf_csr_exram_based_addr_*` register set to `NUM_CH` channels of configurable width, behind a 32-bit CSR read/write port. It sits between the host CSR decoder and the DMA/exram address generators, which consume the committed base addresses.

## Interface
- `NUM_CH`, 8: number of exram base-address channels (1..32)
- `ADDR_BITWIDTH`, 36: width of each base address (33..64)
- `CREDIT_BITWIDTH`, 22: credit counter width (1..32)
- `ID_VALUE`, 32'h414E_0001: constant returned by the ID register
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `csr_wr_en`  in  1  write strobe, one word per cycle
- `csr_rd_en`  in  1  read strobe
- `csr_addr`  in  8  word address
- `csr_wdata`  in  32  write data
- `csr_rdata`  out  32  read data, valid with `csr_rvalid`
- `csr_rvalid`  out  1  read response strobe
- `csr_err`  out  1  pulses with the response or write cycle when the address is unmapped
- `rf_csr_exram_based_addr`  out  NUM_CH*ADDR_BITWIDTH  committed base addresses; channel k occupies bits [k*ADDR_BITWIDTH +: ADDR_BITWIDTH]
- `exram_addr_upd`  out  NUM_CH  one-cycle pulse per channel on commit
- `credit_inc`, `credit_dec`  in  1 each  credit event pulses
- `credit_zero`  out  1  credit equals 0

## Operation
- Word address map:
  - 0x00 ID (RO).
  - 0x01 STATUS (RO): bit0 = `credit_zero`; bits[8 +: NUM_CH] = LSB-pending bitmap.
  - 0x02 CREDIT (RW).
  - 0x03 COUNTER_LSB (RO).
  - 0x04 COUNTER_MSB (RO).
  - 0x05 COUNTER_CTRL: bit0 = enable (RW); bit1 = clear (write-1, self-clearing, reads 0).
  - 0x10+2k: channel k LSB (RW).
  - 0x11+2k: channel k MSB (RW).
- Unmapped address:
  - A write is dropped and `csr_err` pulses.
  - A read returns 0 with `csr_err`=1.
  - A write to an RO register is dropped without an error.
- Address staging and commit:
  - A write to channel k LSB goes to a staging register and sets `pending[k]`. The committed output is not changed.
  - A write to channel k MSB commits {wdata[ADDR_BITWIDTH-33:0], lsb} to the output, where lsb is the staged value if `pending[k]`, otherwise the current committed LSB. The commit clears `pending[k]` and pulses `exram_addr_upd[k]`.
  - MSB bits above ADDR_BITWIDTH-32 are ignored on write and read back as 0.
  - Reading an LSB returns the staged value if pending, otherwise the committed value. Reading an MSB returns the committed value.
- Credit counter, priority highest first:
  - A CSR write to CREDIT loads `wdata[CREDIT_BITWIDTH-1:0]`.
  - `credit_inc` and `credit_dec` in the same cycle leave the count unchanged.
  - `credit_inc` alone increments, saturating at all-ones.
  - `credit_dec` alone decrements, saturating at 0.
- Cycle counter:
  - 64-bit; increments each cycle while enabled; wraps from all-ones to 0.
  - Clear has priority over increment.
  - Reading COUNTER_LSB returns bits [31:0] and latches bits [63:32] into a snapshot. COUNTER_MSB returns the snapshot.

## Timing
- Reset values:
  - `csr_rdata`, `csr_rvalid`, `csr_err`, `exram_addr_upd`: 0.
  - All base addresses, staging registers and pending bits: 0.
  - Credit: 0, so `credit_zero` = 1.
  - Counter, snapshot and enable: 0.
- Reset asserted mid-operation clears all state immediately. A read in flight produces no `csr_rvalid`.
- Writes take effect at the clock edge that samples `csr_wr_en`. The committed output and `exram_addr_upd` appear the following cycle (registered).
- Read latency is 1: `csr_rvalid` is high exactly one cycle after `csr_rd_en`. Back-to-back reads are supported every cycle.
- Read and write in the same cycle (any addresses): both are performed, and the read returns the pre-write value.
- `credit_zero` is registered and tracks the credit register in the same cycle.
- A COUNTER_LSB read returns the counter value at the sampling edge. The snapshot is consistent with that value.

## Structure
- Shared package `andla_csr_pkg`:
  - word-address constants (ID, STATUS, CREDIT, COUNTER_*, EXRAM_BASE = 0x10);
  - `CSR_DATA_BITWIDTH` = 32;
  - the status bit positions.
- Sub-module `andla_csr_exram_chan`, instantiated NUM_CH times. It holds one channel's staging, pending and committed registers, and produces the per-channel update pulse.
- Decode, credit, counter and the read mux live in the top level.

## Test plan
- Reset, then read 0x00 and 0x01 → 0x414E0001, then 0x00000001; `csr_rvalid` one cycle after each `csr_rd_en`.
- Write ch3 LSB=0xDEADBEEF:
  - Output is unchanged, STATUS bit11=1, and reading 0x16 returns 0xDEADBEEF.
  - Then write ch3 MSB=0xFFFFFFF5: next cycle ch3 output = 36'h5DEADBEEF, `exram_addr_upd`=8'h08, STATUS bit11=0, and reading 0x17 returns 0x5.
- Credit:
  - Load 2, then 3 `credit_dec` → 1, 0, 0, with `credit_zero`=1.
  - Load all-ones, then `credit_inc` → unchanged.
  - Inc and dec together → unchanged.
  - CREDIT write together with `credit_inc` → written value.
- Counter: preload near wrap by enabling across 2^32 via a forced bench value. Read LSB=0xFFFFFFFF, let 5 cycles pass, then read MSB → the pre-wrap MSB, not the incremented one. Clear → next LSB read is small.
- Write to 0x08 → `csr_err` pulse and no state change. Read of 0x30 with NUM_CH=8 → rdata 0, `csr_err`=1.
- Assert `rst` asynchronously between a `csr_rd_en` and its response → no `csr_rvalid`, all outputs 0 before the next edge.

Source files
------------

// File: rtl/andla_csr_pkg.sv
// Shared CSR definitions for the exram base-address bank: word addresses,
// status bit positions and the address decoder used by the bank.
package andla_csr_pkg;

    localparam int unsigned CSR_DATA_BITWIDTH = 32;
    localparam int unsigned CSR_ADDR_BITWIDTH = 8;

    localparam logic [7:0] CSR_ADDR_ID         = 8'h00;
    localparam logic [7:0] CSR_ADDR_STATUS     = 8'h01;
    localparam logic [7:0] CSR_ADDR_CREDIT     = 8'h02;
    localparam logic [7:0] CSR_ADDR_CNT_LSB    = 8'h03;
    localparam logic [7:0] CSR_ADDR_CNT_MSB    = 8'h04;
    localparam logic [7:0] CSR_ADDR_CNT_CTRL   = 8'h05;
    localparam logic [7:0] CSR_ADDR_EXRAM_BASE = 8'h10;

    localparam int unsigned STATUS_CREDIT_ZERO_BIT = 0;
    localparam int unsigned STATUS_PENDING_LSB     = 8;

    localparam int unsigned CNT_CTRL_ENABLE_BIT = 0;
    localparam int unsigned CNT_CTRL_CLEAR_BIT  = 1;

    typedef enum logic [2:0] {
        REG_ID       = 3'd0,
        REG_STATUS   = 3'd1,
        REG_CREDIT   = 3'd2,
        REG_CNT_LSB  = 3'd3,
        REG_CNT_MSB  = 3'd4,
        REG_CNT_CTRL = 3'd5,
        REG_CHAN     = 3'd6,
        REG_NONE     = 3'd7
    } csr_reg_e;

    // chan_span is the number of word addresses occupied by the channels (2*NUM_CH)
    function automatic csr_reg_e csr_decode(input logic [7:0] addr, input logic [8:0] chan_span);
        csr_reg_e   kind;
        logic [7:0] off;
        off = addr - CSR_ADDR_EXRAM_BASE;
        case (addr)
            CSR_ADDR_ID:       kind = REG_ID;
            CSR_ADDR_STATUS:   kind = REG_STATUS;
            CSR_ADDR_CREDIT:   kind = REG_CREDIT;
            CSR_ADDR_CNT_LSB:  kind = REG_CNT_LSB;
            CSR_ADDR_CNT_MSB:  kind = REG_CNT_MSB;
            CSR_ADDR_CNT_CTRL: kind = REG_CNT_CTRL;
            default: begin
                if ((addr >= CSR_ADDR_EXRAM_BASE) && ({1'b0, off} < chan_span)) begin
                    kind = REG_CHAN;
                end else begin
                    kind = REG_NONE;
                end
            end
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/andla_csr_exram_chan.sv
// One exram base-address channel: LSB staging register with pending flag,
// committed address register and a one-cycle update pulse on commit.
module andla_csr_exram_chan
    import andla_csr_pkg::*;
#(
    parameter int unsigned ADDR_BITWIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lsb_we_i,
    input  logic                     msb_we_i,
    input  logic [31:0]              wdata_i,
    output logic [ADDR_BITWIDTH-1:0] addr_o,
    output logic [31:0]              rd_lsb_o,
    output logic [31:0]              rd_msb_o,
    output logic                     pending_o,
    output logic                     upd_o
);

    localparam int unsigned MSB_W = ADDR_BITWIDTH - 32;

    logic [31:0]              stage_q,   stage_d;
    logic                     pending_q, pending_d;
    logic [ADDR_BITWIDTH-1:0] addr_q,    addr_d;
    logic                     upd_q,     upd_d;

    // MSB write commits the staged LSB if one is pending, else keeps the committed LSB
    always_comb begin
        stage_d   = stage_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        upd_d     = 1'b0;
        if (msb_we_i) begin
            addr_d    = {wdata_i[MSB_W-1:0], (pending_q ? stage_q : addr_q[31:0])};
            pending_d = 1'b0;
            upd_d     = 1'b1;
        end else if (lsb_we_i) begin
            stage_d   = wdata_i;
            pending_d = 1'b1;
        end else begin
            upd_d     = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q   <= 32'h0000_0000;
            pending_q <= 1'b0;
            addr_q    <= {ADDR_BITWIDTH{1'b0}};
            upd_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            upd_q     <= upd_d;
        end
    end

    assign addr_o    = addr_q;
    assign rd_lsb_o  = pending_q ? stage_q : addr_q[31:0];
    assign rd_msb_o  = 32'(addr_q[ADDR_BITWIDTH-1:32]);
    assign pending_o = pending_q;
    assign upd_o     = upd_q;

endmodule

// File: rtl/andla_csr_exram_bank.sv
// CSR bank for NUM_CH exram base-address channels with a saturating credit
// counter and a 64-bit cycle counter read through an MSB snapshot.
module andla_csr_exram_bank
    import andla_csr_pkg::*;
#(
    parameter int unsigned NUM_CH          = 8,
    parameter int unsigned ADDR_BITWIDTH   = 36,
    parameter int unsigned CREDIT_BITWIDTH = 22,
    parameter logic [31:0] ID_VALUE        = 32'h414E_0001
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            csr_wr_en,
    input  logic                            csr_rd_en,
    input  logic [7:0]                      csr_addr,
    input  logic [31:0]                     csr_wdata,
    output logic [31:0]                     csr_rdata,
    output logic                            csr_rvalid,
    output logic                            csr_err,
    output logic [NUM_CH*ADDR_BITWIDTH-1:0] rf_csr_exram_based_addr,
    output logic [NUM_CH-1:0]               exram_addr_upd,
    input  logic                            credit_inc,
    input  logic                            credit_dec,
    output logic                            credit_zero
);

    localparam logic [8:0]  CHAN_SPAN     = 9'(2 * NUM_CH);
    localparam int unsigned STATUS_PEND_W = (NUM_CH < (CSR_DATA_BITWIDTH - STATUS_PENDING_LSB)) ?
                                            NUM_CH : (CSR_DATA_BITWIDTH - STATUS_PENDING_LSB);

    csr_reg_e   kind_s;
    logic [4:0] ch_idx_s;
    logic       wr_chan_s;
    logic       wr_credit_s;
    logic       wr_ctrl_s;
    logic       rd_cnt_lsb_s;

    logic [NUM_CH-1:0] lsb_we_s;
    logic [NUM_CH-1:0] msb_we_s;
    logic [NUM_CH-1:0] pending_s;
    logic [31:0]       ch_rd_lsb_s [NUM_CH];
    logic [31:0]       ch_rd_msb_s [NUM_CH];

    logic [CREDIT_BITWIDTH-1:0] credit_q, credit_d;
    logic                       credit_zero_q;
    logic [63:0]                cnt_q, cnt_d;
    logic [31:0]                snap_q, snap_d;
    logic                       en_q, en_d;

    logic [31:0] status_s;
    logic [31:0] ch_lsb_sel_s;
    logic [31:0] ch_msb_sel_s;
    logic [31:0] rd_data_s;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        err_q;

    assign kind_s       = csr_decode(csr_addr, CHAN_SPAN);
    // (addr - 0x10) >> 1, computed modulo 32 which covers every legal channel
    assign ch_idx_s     = csr_addr[5:1] - 5'd8;
    assign wr_chan_s    = csr_wr_en && (kind_s == REG_CHAN);
    assign wr_credit_s  = csr_wr_en && (kind_s == REG_CREDIT);
    assign wr_ctrl_s    = csr_wr_en && (kind_s == REG_CNT_CTRL);
    assign rd_cnt_lsb_s = csr_rd_en && (kind_s == REG_CNT_LSB);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign lsb_we_s[k] = wr_chan_s && (ch_idx_s == 5'(k)) && ~csr_addr[0];
        assign msb_we_s[k] = wr_chan_s && (ch_idx_s == 5'(k)) &&  csr_addr[0];

        andla_csr_exram_chan #(
            .ADDR_BITWIDTH(ADDR_BITWIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .lsb_we_i (lsb_we_s[k]),
            .msb_we_i (msb_we_s[k]),
            .wdata_i  (csr_wdata),
            .addr_o   (rf_csr_exram_based_addr[k*ADDR_BITWIDTH +: ADDR_BITWIDTH]),
            .rd_lsb_o (ch_rd_lsb_s[k]),
            .rd_msb_o (ch_rd_msb_s[k]),
            .pending_o(pending_s[k]),
            .upd_o    (exram_addr_upd[k])
        );
    end

    // Credit next state: CSR load, then inc/dec cancel, then saturating inc or dec
    always_comb begin
        credit_d = credit_q;
        if (wr_credit_s) begin
            credit_d = csr_wdata[CREDIT_BITWIDTH-1:0];
        end else if (credit_inc && credit_dec) begin
            credit_d = credit_q;
        end else if (credit_inc) begin
            if (credit_q != {CREDIT_BITWIDTH{1'b1}}) begin
                credit_d = credit_q + CREDIT_BITWIDTH'(1'b1);
            end else begin
                credit_d = credit_q;
            end
        end else if (credit_dec) begin
            if (credit_q != {CREDIT_BITWIDTH{1'b0}}) begin
                credit_d = credit_q - CREDIT_BITWIDTH'(1'b1);
            end else begin
                credit_d = credit_q;
            end
        end else begin
            credit_d = credit_q;
        end
    end

    // Cycle counter, enable and the MSB snapshot taken on every COUNTER_LSB read
    always_comb begin
        cnt_d  = cnt_q;
        en_d   = en_q;
        snap_d = snap_q;
        if (wr_ctrl_s && csr_wdata[CNT_CTRL_CLEAR_BIT]) begin
            cnt_d = 64'h0;
        end else if (en_q) begin
            cnt_d = cnt_q + 64'h1;
        end else begin
            cnt_d = cnt_q;
        end
        if (wr_ctrl_s) begin
            en_d = csr_wdata[CNT_CTRL_ENABLE_BIT];
        end else begin
            en_d = en_q;
        end
        if (rd_cnt_lsb_s) begin
            snap_d = cnt_q[63:32];
        end else begin
            snap_d = snap_q;
        end
    end

    // Read mux over current register values, so a same-cycle write is not visible
    always_comb begin
        status_s = 32'h0000_0000;
        status_s[STATUS_CREDIT_ZERO_BIT] = credit_zero_q;
        status_s[STATUS_PENDING_LSB +: STATUS_PEND_W] = pending_s[STATUS_PEND_W-1:0];
        ch_lsb_sel_s = 32'h0000_0000;
        ch_msb_sel_s = 32'h0000_0000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx_s == 5'(k)) begin
                ch_lsb_sel_s = ch_rd_lsb_s[k];
                ch_msb_sel_s = ch_rd_msb_s[k];
            end else begin
                ch_lsb_sel_s = ch_lsb_sel_s;
                ch_msb_sel_s = ch_msb_sel_s;
            end
        end
        case (kind_s)
            REG_ID:       rd_data_s = ID_VALUE;
            REG_STATUS:   rd_data_s = status_s;
            REG_CREDIT:   rd_data_s = 32'(credit_q);
            REG_CNT_LSB:  rd_data_s = cnt_q[31:0];
            REG_CNT_MSB:  rd_data_s = snap_q;
            REG_CNT_CTRL: rd_data_s = {31'h0000_0000, en_q};
            REG_CHAN:     rd_data_s = csr_addr[0] ? ch_msb_sel_s : ch_lsb_sel_s;
            default:      rd_data_s = 32'h0000_0000;
        endcase
    end

    // Top-level state and registered CSR response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q      <= {CREDIT_BITWIDTH{1'b0}};
            credit_zero_q <= 1'b1;
            cnt_q         <= 64'h0;
            snap_q        <= 32'h0000_0000;
            en_q          <= 1'b0;
            rdata_q       <= 32'h0000_0000;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            credit_zero_q <= (credit_d == {CREDIT_BITWIDTH{1'b0}});
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            en_q          <= en_d;
            rdata_q       <= csr_rd_en ? rd_data_s : 32'h0000_0000;
            rvalid_q      <= csr_rd_en;
            err_q         <= (csr_rd_en || csr_wr_en) && (kind_s == REG_NONE);
        end
    end

    assign csr_rdata   = rdata_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_err     = err_q;
    assign credit_zero = credit_zero_q;

endmodule

// File: tb/tb_andla_csr_exram_bank.sv
// Directed self-checking bench for andla_csr_exram_bank (default parameters).
module tb_andla_csr_exram_bank;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned AW     = 36;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               csr_wr_en = 1'b0;
    logic               csr_rd_en = 1'b0;
    logic [7:0]         csr_addr = 8'h00;
    logic [31:0]        csr_wdata = 32'h0;
    logic [31:0]        csr_rdata;
    logic               csr_rvalid;
    logic               csr_err;
    logic [NUM_CH*AW-1:0] rf_addr;
    logic [NUM_CH-1:0]  exram_addr_upd;
    logic               credit_inc = 1'b0;
    logic               credit_dec = 1'b0;
    logic               credit_zero;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_d;
    logic        rd_v;
    logic        rd_e;

    andla_csr_exram_bank dut (
        .clk                    (clk),
        .rst                    (rst),
        .csr_wr_en              (csr_wr_en),
        .csr_rd_en              (csr_rd_en),
        .csr_addr               (csr_addr),
        .csr_wdata              (csr_wdata),
        .csr_rdata              (csr_rdata),
        .csr_rvalid             (csr_rvalid),
        .csr_err                (csr_err),
        .rf_csr_exram_based_addr(rf_addr),
        .exram_addr_upd         (exram_addr_upd),
        .credit_inc             (credit_inc),
        .credit_dec             (credit_dec),
        .credit_zero            (credit_zero)
    );

    always #5 clk = ~clk;

    // Both helpers start and end on a falling edge
    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wr_en = 1'b1;
        @(negedge clk);
        csr_wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic v, output logic e);
        csr_addr  = a;
        csr_rd_en = 1'b1;
        @(negedge clk);
        csr_rd_en = 1'b0;
        d = csr_rdata;
        v = csr_rvalid;
        e = csr_err;
    endtask

    task automatic test_reset();
        vectors++; if (csr_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", csr_rvalid); end
        vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", csr_rdata); end
        vectors++; if (csr_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", csr_err); end
        vectors++; if (exram_addr_upd !== 8'h00) begin miscompares++; $display("FAIL reset_upd: got %h expected 00", exram_addr_upd); end
        vectors++; if (rf_addr !== {(NUM_CH*AW){1'b0}}) begin miscompares++; $display("FAIL reset_rf: got %h expected 0", rf_addr); end
        vectors++; if (credit_zero !== 1'b1) begin miscompares++; $display("FAIL reset_credit_zero: got %b expected 1", credit_zero); end
        do_read(8'h00, rd_d, rd_v, rd_e);
        vectors++; if (rd_v !== 1'b1 || rd_d !== 32'h414E_0001 || rd_e !== 1'b0) begin miscompares++; $display("FAIL read_id: got v=%b d=%h e=%b expected v=1 d=414e0001 e=0", rd_v, rd_d, rd_e); end
        do_read(8'h01, rd_d, rd_v, rd_e);
        vectors++; if (rd_v !== 1'b1 || rd_d !== 32'h0000_0001) begin miscompares++; $display("FAIL read_status: got v=%b d=%h expected v=1 d=00000001", rd_v, rd_d); end
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_single: got %b expected 0", csr_rvalid); end
        do_read(8'h03, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0) begin miscompares++; $display("FAIL counter_reset: got %h expected 0", rd_d); end
    endtask

    task automatic test_exram_commit();
        do_write(8'h16, 32'hDEAD_BEEF);
        vectors++; if (rf_addr !== {(NUM_CH*AW){1'b0}}) begin miscompares++; $display("FAIL stage_no_commit: got %h expected 0", rf_addr); end
        vectors++; if (exram_addr_upd !== 8'h00) begin miscompares++; $display("FAIL stage_no_upd: got %h expected 00", exram_addr_upd); end
        do_read(8'h01, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0801) begin miscompares++; $display("FAIL status_pending: got %h expected 00000801", rd_d); end
        do_read(8'h16, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_staged_lsb: got %h expected deadbeef", rd_d); end
        do_read(8'h17, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0) begin miscompares++; $display("FAIL read_msb_precommit: got %h expected 0", rd_d); end
        do_write(8'h17, 32'hFFFF_FFF5);
        vectors++; if (rf_addr[3*AW +: AW] !== 36'h5_DEAD_BEEF) begin miscompares++; $display("FAIL commit_ch3: got %h expected 5deadbeef", rf_addr[3*AW +: AW]); end
        vectors++; if (exram_addr_upd !== 8'h08) begin miscompares++; $display("FAIL commit_upd: got %h expected 08", exram_addr_upd); end
        do_read(8'h01, rd_d, rd_v, rd_e);
        vectors++; if (exram_addr_upd !== 8'h00) begin miscompares++; $display("FAIL upd_one_cycle: got %h expected 00", exram_addr_upd); end
        vectors++; if (rd_d !== 32'h0000_0001) begin miscompares++; $display("FAIL status_cleared: got %h expected 00000001", rd_d); end
        do_read(8'h17, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0005) begin miscompares++; $display("FAIL read_msb: got %h expected 00000005", rd_d); end
        // MSB write with nothing staged keeps the committed LSB (zero for ch0)
        do_write(8'h11, 32'h0000_000A);
        vectors++; if (rf_addr[0 +: AW] !== 36'hA_0000_0000) begin miscompares++; $display("FAIL commit_ch0: got %h expected a00000000", rf_addr[0 +: AW]); end
        vectors++; if (exram_addr_upd !== 8'h01) begin miscompares++; $display("FAIL commit_ch0_upd: got %h expected 01", exram_addr_upd); end
        // read and write of the same LSB in one cycle: read sees the old value
        csr_addr  = 8'h16;
        csr_wdata = 32'h1234_5678;
        csr_wr_en = 1'b1;
        csr_rd_en = 1'b1;
        @(negedge clk);
        csr_wr_en = 1'b0;
        csr_rd_en = 1'b0;
        vectors++; if (csr_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rw_same_cycle: got %h expected deadbeef", csr_rdata); end
        do_read(8'h16, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h1234_5678) begin miscompares++; $display("FAIL rw_after: got %h expected 12345678", rd_d); end
        do_write(8'h17, 32'h0000_000C);
        vectors++; if (rf_addr[3*AW +: AW] !== 36'hC_1234_5678) begin miscompares++; $display("FAIL recommit_ch3: got %h expected c12345678", rf_addr[3*AW +: AW]); end
    endtask

    task automatic test_credit();
        do_write(8'h02, 32'h0000_0002);
        vectors++; if (credit_zero !== 1'b0) begin miscompares++; $display("FAIL credit_load_zero: got %b expected 0", credit_zero); end
        for (int i = 0; i < 3; i++) begin
            credit_dec = 1'b1;
            @(negedge clk);
            credit_dec = 1'b0;
            do_read(8'h02, rd_d, rd_v, rd_e);
            vectors++; if (rd_d !== ((i == 0) ? 32'h1 : 32'h0)) begin miscompares++; $display("FAIL credit_dec%0d: got %h expected %h", i, rd_d, ((i == 0) ? 32'h1 : 32'h0)); end
            vectors++; if (credit_zero !== (i != 0)) begin miscompares++; $display("FAIL credit_zero_dec%0d: got %b expected %b", i, credit_zero, (i != 0)); end
        end
        do_write(8'h02, 32'hFFFF_FFFF);
        credit_inc = 1'b1;
        @(negedge clk);
        credit_inc = 1'b0;
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h003F_FFFF) begin miscompares++; $display("FAIL credit_sat_hi: got %h expected 003fffff", rd_d); end
        do_write(8'h02, 32'h0000_0005);
        credit_inc = 1'b1;
        credit_dec = 1'b1;
        @(negedge clk);
        credit_dec = 1'b0;
        credit_inc = 1'b0;
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0005) begin miscompares++; $display("FAIL credit_inc_dec: got %h expected 00000005", rd_d); end
        credit_inc = 1'b1;
        @(negedge clk);
        credit_inc = 1'b0;
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0006) begin miscompares++; $display("FAIL credit_inc: got %h expected 00000006", rd_d); end
        credit_inc = 1'b1;
        do_write(8'h02, 32'h0000_0009);
        credit_inc = 1'b0;
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0009) begin miscompares++; $display("FAIL credit_write_prio: got %h expected 00000009", rd_d); end
    endtask

    task automatic test_counter();
        // counter is disabled, so a forced value is held across the edge and kept on release
        force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        do_write(8'h05, 32'h0000_0001);
        do_read(8'h03, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cnt_lsb_prewrap: got %h expected ffffffff", rd_d); end
        repeat (5) @(negedge clk);
        do_read(8'h04, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0001) begin miscompares++; $display("FAIL cnt_snapshot: got %h expected 00000001", rd_d); end
        do_read(8'h03, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0006) begin miscompares++; $display("FAIL cnt_lsb_run: got %h expected 00000006", rd_d); end
        do_read(8'h04, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0002) begin miscompares++; $display("FAIL cnt_msb_postwrap: got %h expected 00000002", rd_d); end
        do_write(8'h05, 32'h0000_0003);
        do_read(8'h03, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0000) begin miscompares++; $display("FAIL cnt_clear: got %h expected 00000000", rd_d); end
        do_read(8'h05, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0001) begin miscompares++; $display("FAIL cnt_ctrl: got %h expected 00000001", rd_d); end
        do_write(8'h05, 32'h0000_0000);
    endtask

    task automatic test_unmapped();
        do_write(8'h08, 32'hFFFF_FFFF);
        vectors++; if (csr_err !== 1'b1) begin miscompares++; $display("FAIL wr_unmapped_err: got %b expected 1", csr_err); end
        @(negedge clk);
        vectors++; if (csr_err !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle: got %b expected 0", csr_err); end
        do_write(8'h00, 32'h0000_0000);
        vectors++; if (csr_err !== 1'b0) begin miscompares++; $display("FAIL wr_ro_err: got %b expected 0", csr_err); end
        do_read(8'h00, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h414E_0001) begin miscompares++; $display("FAIL ro_unchanged: got %h expected 414e0001", rd_d); end
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0000_0009) begin miscompares++; $display("FAIL unmapped_no_effect: got %h expected 00000009", rd_d); end
        do_read(8'h30, rd_d, rd_v, rd_e);
        vectors++; if (rd_v !== 1'b1 || rd_d !== 32'h0 || rd_e !== 1'b1) begin miscompares++; $display("FAIL rd_unmapped: got v=%b d=%h e=%b expected v=1 d=0 e=1", rd_v, rd_d, rd_e); end
        do_read(8'h20, rd_d, rd_v, rd_e);
        vectors++; if (rd_e !== 1'b1 || rd_d !== 32'h0) begin miscompares++; $display("FAIL rd_past_last_ch: got d=%h e=%b expected d=0 e=1", rd_d, rd_e); end
        do_read(8'h1F, rd_d, rd_v, rd_e);
        vectors++; if (rd_e !== 1'b0 || rd_d !== 32'h0) begin miscompares++; $display("FAIL rd_last_ch_msb: got d=%h e=%b expected d=0 e=0", rd_d, rd_e); end
    endtask

    task automatic test_back_to_back();
        csr_rd_en = 1'b1;
        csr_addr  = 8'h00;
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h414E_0001) begin miscompares++; $display("FAIL b2b_0: got v=%b d=%h expected v=1 d=414e0001", csr_rvalid, csr_rdata); end
        csr_addr = 8'h02;
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0000_0009) begin miscompares++; $display("FAIL b2b_1: got v=%b d=%h expected v=1 d=00000009", csr_rvalid, csr_rdata); end
        csr_addr = 8'h11;
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0000_000A) begin miscompares++; $display("FAIL b2b_2: got v=%b d=%h expected v=1 d=0000000a", csr_rvalid, csr_rdata); end
        csr_rd_en = 1'b0;
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b expected 0", csr_rvalid); end
    endtask

    task automatic test_async_reset();
        csr_addr  = 8'h00;
        csr_rd_en = 1'b1;
        @(negedge clk);
        vectors++; if (csr_rvalid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_rvalid: got %b expected 1", csr_rvalid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0 || csr_err !== 1'b0) begin miscompares++; $display("FAIL async_rst_resp: got v=%b d=%h e=%b expected all 0", csr_rvalid, csr_rdata, csr_err); end
        vectors++; if (rf_addr !== {(NUM_CH*AW){1'b0}} || exram_addr_upd !== 8'h00) begin miscompares++; $display("FAIL async_rst_rf: got %h upd=%h expected 0", rf_addr, exram_addr_upd); end
        vectors++; if (credit_zero !== 1'b1) begin miscompares++; $display("FAIL async_rst_credit_zero: got %b expected 1", credit_zero); end
        @(negedge clk);
        csr_rd_en = 1'b0;
        vectors++; if (csr_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_no_rvalid: got %b expected 0", csr_rvalid); end
        rst = 1'b0;
        do_read(8'h02, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0) begin miscompares++; $display("FAIL post_rst_credit: got %h expected 0", rd_d); end
        do_read(8'h16, rd_d, rd_v, rd_e);
        vectors++; if (rd_d !== 32'h0) begin miscompares++; $display("FAIL post_rst_lsb: got %h expected 0", rd_d); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_exram_commit();
        test_credit();
        test_counter();
        test_unmapped();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
